// File: rtl/buffer_pkg.sv
// Shared defaults and word/address types for the ping-pong frame buffer.
package buffer_pkg;

   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_RAM_DEPTH  = 1 << DEF_ADDR_WIDTH;

   typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/buffer_bram.sv
// One bank of the frame buffer: simple dual-port RAM with a registered, enabled read port.
// Define BUFFER_MEM_INIT_EN to zero the storage at time 0.
module bram
   import buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] bram [RAM_DEPTH];

`ifdef BUFFER_MEM_INIT_EN
   initial begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
         bram[i] = '0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (w_en) begin
         bram[w_addr] <= din;
      end
   end

   // Output register reset maps onto the block RAM's output-latch reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (r_en) begin
         dout <= bram[r_addr];
      end
   end

endmodule

// File: rtl/buffer.sv
// Ping-pong frame buffer: producer fills the back bank while the consumer reads the front.
// Bank init at time 0 is controlled by BUFFER_MEM_INIT_EN (see bram).
module buffer
   import buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  swap_en,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic                  cur_buff;
   logic                  rd_sel;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] a_dout;
   logic [DATA_WIDTH-1:0] b_dout;

   assign wr_ok = rst_n && en && w_en;

   // rd_sel remembers which bank produced the last read, so the output mux
   // stays aligned with the one-cycle read latency across a swap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_buff <= 1'b0;
         rd_sel   <= 1'b0;
      end else if (en) begin
         rd_sel <= cur_buff;
         if (swap_en) begin
            cur_buff <= ~cur_buff;
         end
      end
   end

   bram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RAM_DEPTH (RAM_DEPTH)
   ) buff_a (
      .clk   (clk),
      .rst_n (rst_n),
      .w_en  (wr_ok && cur_buff),
      .w_addr(w_addr),
      .din   (din),
      .r_en  (en && !cur_buff),
      .r_addr(r_addr),
      .dout  (a_dout)
   );

   bram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RAM_DEPTH (RAM_DEPTH)
   ) buff_b (
      .clk   (clk),
      .rst_n (rst_n),
      .w_en  (wr_ok && !cur_buff),
      .w_addr(w_addr),
      .din   (din),
      .r_en  (en && cur_buff),
      .r_addr(r_addr),
      .dout  (b_dout)
   );

   assign dout = rd_sel ? b_dout : a_dout;

endmodule

// File: tb/tb_buffer.sv
// Directed, table-driven bench for the ping-pong buffer.
module tb_buffer;
   import buffer_pkg::*;

   typedef struct {
      logic  rst_n;
      logic  en;
      logic  swap_en;
      logic  w_en;
      addr_t w_addr;
      addr_t r_addr;
      data_t din;
      logic  exp_cur;
      logic  chk_dout;
      data_t exp_dout;
   } vec_t;

   localparam int NUM_VECS = 18;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  en = 1'b0;
   logic  swap_en = 1'b0;
   logic  w_en = 1'b0;
   addr_t w_addr = '0;
   addr_t r_addr = '0;
   data_t din = '0;
   data_t dout;

   int    num_checks = 0;
   int    num_fails = 0;
   vec_t  vecs [NUM_VECS];

   buffer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .swap_en(swap_en),
      .w_en   (w_en),
      .w_addr (w_addr),
      .r_addr (r_addr),
      .din    (din),
      .dout   (dout)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst_n   = v.rst_n;
      en      = v.en;
      swap_en = v.swap_en;
      w_en    = v.w_en;
      w_addr  = v.w_addr;
      r_addr  = v.r_addr;
      din     = v.din;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkNot(input string name, input logic [31:0] actual, input logic [31:0] forbidden);
      num_checks++;
      if (actual === forbidden) begin
         num_fails++;
         $display("[TB] FAIL %s: got %h, expected anything but %h", name, actual, forbidden);
      end
   endtask

   initial begin
      //            rst en sw we w_addr   r_addr   din     cur chk dout
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 12'h000, 1'b0, 1'b1, 12'h000};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h155, 10'h000, 12'h777, 1'b0, 1'b1, 12'h000};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 12'hABC, 1'b0, 1'b0, 12'h000};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h155, 12'h000, 1'b1, 1'b0, 12'h000};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 10'h155, 12'h000, 1'b1, 1'b1, 12'hABC};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h155, 10'h155, 12'h123, 1'b1, 1'b1, 12'hABC};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h020, 10'h155, 12'h5A5, 1'b1, 1'b1, 12'hABC};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h155, 12'h000, 1'b0, 1'b1, 12'hABC};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 10'h020, 12'h000, 1'b0, 1'b1, 12'h5A5};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h020, 12'hFFF, 1'b1, 1'b1, 12'h5A5};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 10'h3FF, 12'h000, 1'b1, 1'b1, 12'hFFF};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h3FF, 12'h000, 1'b0, 1'b1, 12'hFFF};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h020, 12'h000, 1'b1, 1'b1, 12'h5A5};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h155, 12'h000, 1'b0, 1'b1, 12'hABC};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 10'h020, 12'h000, 1'b0, 1'b1, 12'h5A5};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h020, 10'h020, 12'h111, 1'b0, 1'b1, 12'h5A5};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h3FF, 12'h000, 1'b0, 1'b1, 12'h5A5};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h001, 10'h020, 12'h222, 1'b0, 1'b1, 12'h000};

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("cur_buff[%0d]", i), {31'd0, dut.cur_buff}, {31'd0, vecs[i].exp_cur});
         if (vecs[i].chk_dout) begin
            checkOutput($sformatf("dout[%0d]", i), {20'd0, dout}, {20'd0, vecs[i].exp_dout});
         end
         case (i)
            1: checkNot("reset_write_dropped", {20'd0, dut.buff_b.bram[10'h155]}, 32'h777);
            2: checkOutput("back_b_written", {20'd0, dut.buff_b.bram[10'h155]}, 32'hABC);
            5: begin
               checkOutput("disabled_b_kept", {20'd0, dut.buff_b.bram[10'h155]}, 32'hABC);
               checkNot("disabled_a_untouched", {20'd0, dut.buff_a.bram[10'h155]}, 32'h123);
            end
            6: checkOutput("back_a_written", {20'd0, dut.buff_a.bram[10'h020]}, 32'h5A5);
            9: checkOutput("write_swap_b", {20'd0, dut.buff_b.bram[10'h3FF]}, 32'hFFF);
            15: begin
               checkOutput("same_addr_b", {20'd0, dut.buff_b.bram[10'h020]}, 32'h111);
               checkOutput("same_addr_a", {20'd0, dut.buff_a.bram[10'h020]}, 32'h5A5);
            end
            17: checkNot("reset_write_dropped2", {20'd0, dut.buff_b.bram[10'h001]}, 32'h222);
            default: ;
         endcase
      end

      // Held swap toggles the front bank on every edge; reads track the bank in front before each edge.
      begin
         vec_t v;
         logic exp_cur;
         exp_cur = 1'b0;
         v = '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h020, 12'h000, 1'b0, 1'b0, 12'h000};
         for (int k = 0; k < 4; k++) begin
            logic pre;
            pre = exp_cur;
            exp_cur = ~exp_cur;
            applyStimulus(v);
            checkOutput($sformatf("toggle_cur[%0d]", k), {31'd0, dut.cur_buff}, {31'd0, exp_cur});
            checkOutput($sformatf("toggle_dout[%0d]", k), {20'd0, dout}, pre ? 32'h111 : 32'h5A5);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
